// File: rtl/cbc_pkg.sv
// Shared CBC definitions: EEPROM scheduler states, word addresses and ack codes.
// Also holds the sizing helper for the shared access timer.
package cbc_pkg;

    typedef enum logic [2:0] {
        EEP_IDLE     = 3'd0,
        EEP_RD       = 3'd1,
        EEP_WR_SETUP = 3'd2,
        EEP_WR_PUMP  = 3'd3,
        EEP_WR_HOLD  = 3'd4,
        EEP_DONE     = 3'd5
    } eep_st_t;

    localparam logic [1:0]  EEP_XSET = 2'd0;
    localparam logic [1:0]  EEP_P    = 2'd1;
    localparam logic [1:0]  EEP_I    = 2'd2;
    localparam logic [1:0]  EEP_D    = 2'd3;

    localparam logic [13:0] POSACK = 14'h0A5A;
    localparam logic [13:0] NEGACK = 14'h05A5;

    // Timer must hold the larger of the two reload values.
    function automatic int unsigned tmr_width(input int unsigned rd_lat, input int unsigned cp_cycles);
        int unsigned big;
        big = (rd_lat > cp_cycles) ? rd_lat : cp_cycles;
        return (big < 32'd1) ? 32'd1 : $clog2(big + 32'd1);
    endfunction

endpackage

// File: rtl/eep_tmr.sv
// Loadable down-counter with a zero flag; shared by the read wait and the
// charge-pump interval of the EEPROM scheduler.
module eep_tmr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/eep_sched.sv
// EEPROM access scheduler: arbitrates the control loop (read-only) and the
// command handler (read/write) onto the single 4-word EEPROM.
module eep_sched
    import cbc_pkg::*;
#(
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned CP_CYCLES = 1500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lp_req,
    input  logic [1:0]  lp_addr,
    output logic        lp_done,
    input  logic        cm_req,
    input  logic        cm_wr,
    input  logic [1:0]  cm_addr,
    input  logic [13:0] cm_wdata,
    output logic        cm_done,
    output logic [13:0] rd_data,
    output logic        busy,
    output logic [1:0]  eep_addr,
    output logic [13:0] eep_wr_data,
    input  logic [13:0] eep_rd_data,
    output logic        eep_cs_n,
    output logic        eep_r_w_n,
    output logic        chrg_pmp_en
);

    localparam int unsigned   TW      = tmr_width(RD_LAT, CP_CYCLES);
    localparam logic [TW-1:0] RD_LOAD = TW'(RD_LAT - 1);
    localparam logic [TW-1:0] CP_LOAD = TW'(CP_CYCLES - 1);

    eep_st_t      r_state;
    logic         r_last_lp;
    logic         r_win_lp;
    logic         r_lp_done;
    logic         r_cm_done;
    logic [13:0]  r_rd_data;
    logic         r_busy;
    logic [1:0]   r_eep_addr;
    logic [13:0]  r_eep_wr_data;
    logic         r_eep_cs_n;
    logic         r_eep_r_w_n;
    logic         r_chrg_pmp_en;

    logic         w_any;
    logic         w_pick_lp;
    logic         w_wr_grant;
    logic         w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic         w_tmr_dec;
    logic         w_tmr_zero;

    eep_tmr #(.W(TW)) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Arbitration (loop wins ties unless it won last) and timer control.
    always_comb begin
        w_any      = lp_req | cm_req;
        w_pick_lp  = lp_req & (~cm_req | ~r_last_lp);
        w_wr_grant = ~w_pick_lp & cm_req & cm_wr;
        w_tmr_load = 1'b0;
        w_tmr_val  = {TW{1'b0}};
        w_tmr_dec  = 1'b0;
        case (r_state)
            EEP_IDLE: begin
                if (w_any && !w_wr_grant) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RD_LOAD;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            EEP_RD, EEP_WR_PUMP: begin
                w_tmr_dec = ~w_tmr_zero;
            end
            EEP_WR_SETUP: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = CP_LOAD;
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    // Access sequencer; every EEPROM-facing output is a register set one edge ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= EEP_IDLE;
            r_last_lp     <= 1'b0;
            r_win_lp      <= 1'b0;
            r_lp_done     <= 1'b0;
            r_cm_done     <= 1'b0;
            r_rd_data     <= 14'd0;
            r_busy        <= 1'b0;
            r_eep_addr    <= 2'd0;
            r_eep_wr_data <= 14'd0;
            r_eep_cs_n    <= 1'b1;
            r_eep_r_w_n   <= 1'b1;
            r_chrg_pmp_en <= 1'b0;
        end else begin
            case (r_state)
                EEP_IDLE: begin
                    r_lp_done <= 1'b0;
                    r_cm_done <= 1'b0;
                    if (w_any) begin
                        r_win_lp    <= w_pick_lp;
                        r_last_lp   <= w_pick_lp;
                        r_eep_addr  <= w_pick_lp ? lp_addr : cm_addr;
                        r_busy      <= 1'b1;
                        r_eep_cs_n  <= 1'b0;
                        r_eep_r_w_n <= ~w_wr_grant;
                        if (w_wr_grant) begin
                            r_eep_wr_data <= cm_wdata;
                            r_state       <= EEP_WR_SETUP;
                        end else begin
                            r_state <= EEP_RD;
                        end
                    end else begin
                        r_state <= EEP_IDLE;
                    end
                end
                EEP_RD: begin
                    if (w_tmr_zero) begin
                        r_rd_data   <= eep_rd_data;
                        r_eep_cs_n  <= 1'b1;
                        r_eep_r_w_n <= 1'b1;
                        r_lp_done   <= r_win_lp;
                        r_cm_done   <= ~r_win_lp;
                        r_state     <= EEP_DONE;
                    end else begin
                        r_state <= EEP_RD;
                    end
                end
                EEP_WR_SETUP: begin
                    r_chrg_pmp_en <= 1'b1;
                    r_state       <= EEP_WR_PUMP;
                end
                EEP_WR_PUMP: begin
                    if (w_tmr_zero) begin
                        r_chrg_pmp_en <= 1'b0;
                        r_state       <= EEP_WR_HOLD;
                    end else begin
                        r_state <= EEP_WR_PUMP;
                    end
                end
                EEP_WR_HOLD: begin
                    r_eep_cs_n  <= 1'b1;
                    r_eep_r_w_n <= 1'b1;
                    r_lp_done   <= r_win_lp;
                    r_cm_done   <= ~r_win_lp;
                    r_state     <= EEP_DONE;
                end
                EEP_DONE: begin
                    r_lp_done <= 1'b0;
                    r_cm_done <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= EEP_IDLE;
                end
                default: begin
                    r_eep_cs_n    <= 1'b1;
                    r_eep_r_w_n   <= 1'b1;
                    r_chrg_pmp_en <= 1'b0;
                    r_lp_done     <= 1'b0;
                    r_cm_done     <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= EEP_IDLE;
                end
            endcase
        end
    end

    assign lp_done     = r_lp_done;
    assign cm_done     = r_cm_done;
    assign rd_data     = r_rd_data;
    assign busy        = r_busy;
    assign eep_addr    = r_eep_addr;
    assign eep_wr_data = r_eep_wr_data;
    assign eep_cs_n    = r_eep_cs_n;
    assign eep_r_w_n   = r_eep_r_w_n;
    assign chrg_pmp_en = r_chrg_pmp_en;

endmodule

// File: doc/eep_sched.md
# eep_sched

EEPROM access scheduler for the CBC digital core. It shares the single 4-word EEPROM (Xset, P, I, D) between two requesters: the control loop, which only reads coefficients, and the config-UART command handler, which reads and writes. It arbitrates between them, sequences `eep_cs_n`, `eep_r_w_n` and `eep_addr`, and times the charge pump for writes. It returns read data and a completion pulse to whichever requester it granted.

## Interface
- `RD_LAT`, default 2: number of cycles `eep_cs_n` is held low for a read before `eep_rd_data` is sampled (min 1).
- `CP_CYCLES`, default 1500000: number of cycles `chrg_pmp_en` is high per write (3 ms at 500 MHz); min 1, counter width `$clog2(CP_CYCLES+1)`.
- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `lp_req` in 1: control-loop read request, a level held until `lp_done`.
- `lp_addr` in 2: control-loop word address.
- `lp_done` out 1: one-cycle pulse; `rd_data` is valid in that cycle.
- `cm_req` in 1: command-handler request, a level held until `cm_done`.
- `cm_wr` in 1: 1 = write, 0 = read; qualified by `cm_req`.
- `cm_addr` in 2: command word address.
- `cm_wdata` in 14: write data.
- `cm_done` out 1: one-cycle pulse.
- `rd_data` out 14: last read word, registered.
- `busy` out 1: high in every state except IDLE.
- `eep_addr` out 2: EEPROM address.
- `eep_wr_data` out 14: EEPROM write data (`dst` bus).
- `eep_rd_data` in 14: EEPROM read data.
- `eep_cs_n` out 1: EEPROM chip select, active low.
- `eep_r_w_n` out 1: 1 = read, 0 = write.
- `chrg_pmp_en` out 1: charge pump enable.

## Operation
- **States:** IDLE, RD, WR_SETUP, WR_PUMP, WR_HOLD, DONE.
- **IDLE arbitration, one candidate:** if only one requester has its request high, that requester is granted.
- **IDLE arbitration, both requesting:** the loop wins, unless the last grant went to the loop. In that case the command handler wins (alternation, so neither requester starves).
- **Grant latch:** at the grant, the address, write data, op and winner are latched. Requester inputs are ignored until DONE.
- **Grant to read:** go to RD.
- **Grant to command write:** go to WR_SETUP.
- **RD:** `eep_cs_n`=0, `eep_r_w_n`=1 for `RD_LAT` cycles. On the last RD cycle, `eep_rd_data` is registered into `rd_data`. Then go to DONE.
- **WR_SETUP:** 1 cycle with `eep_cs_n`=0, `eep_r_w_n`=0, address and data driven, `chrg_pmp_en`=0.
- **WR_PUMP:** `CP_CYCLES` cycles with `chrg_pmp_en`=1; cs, r_w_n, address and data unchanged.
- **WR_HOLD:** 1 cycle with `chrg_pmp_en`=0; cs and r_w_n still asserted, address and data stable.
- **DONE:** 1 cycle; `eep_cs_n`=1, `eep_r_w_n`=1, and the winner's done output pulses. Then go to IDLE.
- **Write leaves `rd_data` unchanged.**
- **`eep_addr` / `eep_wr_data`:** hold their last latched values while idle; no toggling outside a grant.

## Timing
- **Reset values:** `eep_cs_n`=1, `eep_r_w_n`=1, `chrg_pmp_en`=0, `eep_addr`=0, `eep_wr_data`=0, `rd_data`=0, `lp_done`=0, `cm_done`=0, `busy`=0. The last-grant pointer resets to "command", so the loop wins the first tie.
- **Read latency:** request first seen high in IDLE at cycle k → done at k+1+`RD_LAT`.
- **Write latency:** request first seen high in IDLE at cycle k → done at k+3+`CP_CYCLES`.
- **`chrg_pmp_en` guarantee:** never high unless `eep_cs_n`=0 and `eep_r_w_n`=0. It is always exactly `CP_CYCLES` contiguous cycles.
- **Handshake:** the requester deasserts its request no later than the cycle after its done pulse. A request still high in that IDLE cycle is treated as a new request.
- **Request drop before done:** dropping the request mid-access does not abort it; done still pulses.
- **Reset mid-operation:** any state goes to IDLE on the next edge with reset values. `chrg_pmp_en` falls in that same cycle, and no done pulse is issued.
- **Back-to-back:** minimum gap between accesses is 1 IDLE cycle after DONE.

## Structure
- **Shared package `cbc_pkg`:**
  - state enum `eep_st_t`.
  - address constants `EEP_XSET`=0, `EEP_P`=1, `EEP_I`=2, `EEP_D`=3.
  - ack codes `POSACK`=14'h0A5A and `NEGACK`=14'h05A5, for the command handler.
- **Sub-module `eep_tmr`:** loadable down-counter with a `zero` flag. It is shared by RD (load `RD_LAT`-1) and WR_PUMP (load `CP_CYCLES`-1).

## Test plan
All scenarios use `RD_LAT`=2, `CP_CYCLES`=8, with the eep model preloaded to {0x0100, 0x0800, 0x0040, 0x0010}.
1. **Loop read:** `lp_req` with `lp_addr`=1 → `eep_cs_n` low for 2 cycles, `lp_done` at k+3, `rd_data`=0x0800, `cm_done` stays 0.
2. **Command write then read back:** `cm_req`, `cm_wr`=1, `cm_addr`=0, `cm_wdata`=0x1234 → `chrg_pmp_en` high exactly 8 cycles inside the cs/r_w_n-low window, `cm_done` at k+11. A following command read of addr 0 returns 0x1234.
3. **Simultaneous requests:** after reset, `lp_req` and `cm_req` rise together and are held → loop is served first, then command. Holding both for 4 accesses gives the grant order L, C, L, C.
4. **Reset mid-write:** assert `rst` in the 4th WR_PUMP cycle → next cycle `chrg_pmp_en`=0, `eep_cs_n`=1, `busy`=0, no done pulse. The word is not required to be updated.
5. **Request dropped early:** `cm_req` read of addr 3 is deasserted during RD → `cm_done` still pulses and `rd_data`=0x0010. No second access occurs.
6. **Protocol checker (all scenarios):** `chrg_pmp_en` implies `!eep_cs_n && !eep_r_w_n`, and `lp_done`/`cm_done` are never high together.
